mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL declare parameter XLEN, default 32, data/address width.
REQ-002 SHALL declare parameter MASKW, default XLEN/8, write byte-mask width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports ifu_valid in 1, ifu_addr in XLEN: fetch request and address.
REQ-006 SHALL have ports ifu_ready out 1, ifu_rvalid out 1, ifu_rdata out XLEN: fetch accept pulse, response pulse, instruction.
REQ-007 SHALL have ports lsu_valid in 1, lsu_wen in 1, lsu_addr in XLEN, lsu_wdata in XLEN, lsu_wmask in MASKW: load/store request.
REQ-008 SHALL have ports lsu_ready out 1, lsu_rvalid out 1, lsu_rdata out XLEN: accept pulse, response pulse (read data or write ack), load data.
REQ-009 SHALL have ports mem_valid out 1, mem_wen out 1, mem_addr out XLEN, mem_wdata out XLEN, mem_wmask out MASKW: shared memory request.
REQ-010 SHALL have ports mem_ready in 1, mem_rvalid in 1, mem_rdata in XLEN: memory accept and response.
REQ-011 SHALL have ports busy out 1 (state != IDLE) and err out 1 (sticky protocol error).

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT; exactly one transaction outstanding.
REQ-013 IDLE: if any requester valid, SHALL grant one, assert its *_ready combinationally that cycle, latch payload and owner, go to REQ.
REQ-014 Both valid in IDLE: SHALL grant the requester not granted last (round-robin); after reset, LSU wins first tie.
REQ-015 Single valid: SHALL grant it regardless of round-robin pointer; pointer SHALL update to the granted requester on every grant.
REQ-016 IFU transactions SHALL drive mem_wen=0, mem_wdata=0, mem_wmask=0.
REQ-017 REQ: SHALL hold mem_valid=1 and latched payload stable until mem_ready=1, then go to WAIT next cycle.
REQ-018 WAIT: on mem_rvalid=1 SHALL assert owner's *_rvalid for that cycle with *_rdata=mem_rdata (combinational pass-through), return to IDLE.
REQ-019 Non-owner *_rvalid SHALL be 0; *_rdata SHALL be 0 whenever its *_rvalid=0.
REQ-020 A new grant SHALL NOT occur in the cycle a response is delivered; earliest next accept is the following cycle (IDLE).
REQ-021 Minimum accept-to-response latency SHALL be 2 cycles (accept in cycle N, mem_ready in N+1, mem_rvalid in N+2); a request arriving while busy waits with valid held.
REQ-022 mem_rvalid outside WAIT SHALL be ignored for forwarding and SHALL set err; err stays 1 until reset.
REQ-023 mem_valid SHALL be 0 in IDLE and WAIT; *_ready SHALL be 0 outside IDLE.
REQ-024 Requesters deasserting valid before ready SHALL NOT be granted; no request is queued internally.

Reset
REQ-025 While rst=0 at a clock edge: state=IDLE, round-robin pointer=IFU-last (LSU preferred), err=0, latched payload=0.
REQ-026 Outputs during/after reset: all *_ready, *_rvalid, mem_valid, busy, err = 0; data/address outputs = 0.
REQ-027 Reset in REQ or WAIT SHALL abandon the transaction; a later mem_rvalid for it SHALL not be forwarded and SHALL set err.

Verification
REQ-028 IFU only, addr 0x80000000, mem_ready=1 in REQ, mem_rvalid next cycle with 0x00000413 -> ifu_ready cycle 0, mem_valid cycle 1, ifu_rvalid/ifu_rdata=0x00000413 cycle 2, lsu_* silent.
REQ-029 Both valid after reset, continuously re-requesting -> grant order LSU, IFU, LSU, IFU; each grant 1 cycle after previous response.
REQ-030 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_ready delayed 3 cycles -> mem_* held stable all 4 REQ cycles, lsu_rvalid on ack, lsu_rdata passes mem_rdata.
REQ-031 mem_rvalid=1 pulsed in IDLE -> no rvalid to either side, err=1 and stays 1 until rst=0.
REQ-032 rst=0 for one cycle during WAIT -> busy=0 next cycle, subsequent mem_rvalid not forwarded, err=1; new IFU request then served normally.
REQ-033 IFU valid dropped before grant while LSU busy -> IFU never granted, no mem transaction issued for it.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if -- bundle of every handshake/bus signal around the memory arbiter.
//   ifu_*  : instruction-fetch requester (read only)
//   lsu_*  : load/store requester
//   mem_*  : shared memory port
//   busy/err : arbiter status
// Modports:
//   slave  : arbiter view (accepts requester traffic, drives the memory port)
//   master : environment view (requesters, memory model, status observer)
interface mem_arb_if #(
   parameter int XLEN  = 32,
   parameter int MASKW = XLEN/8
);
   logic             ifu_valid;
   logic [XLEN-1:0]  ifu_addr;
   logic             ifu_ready;
   logic             ifu_rvalid;
   logic [XLEN-1:0]  ifu_rdata;

   logic             lsu_valid;
   logic             lsu_wen;
   logic [XLEN-1:0]  lsu_addr;
   logic [XLEN-1:0]  lsu_wdata;
   logic [MASKW-1:0] lsu_wmask;
   logic             lsu_ready;
   logic             lsu_rvalid;
   logic [XLEN-1:0]  lsu_rdata;

   logic             mem_valid;
   logic             mem_wen;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_wdata;
   logic [MASKW-1:0] mem_wmask;
   logic             mem_ready;
   logic             mem_rvalid;
   logic [XLEN-1:0]  mem_rdata;

   logic             busy;
   logic             err;

   modport slave (
      input  ifu_valid, ifu_addr,
      output ifu_ready, ifu_rvalid, ifu_rdata,
      input  lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      output lsu_ready, lsu_rvalid, lsu_rdata,
      output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata,
      output busy, err
   );

   modport master (
      output ifu_valid, ifu_addr,
      input  ifu_ready, ifu_rvalid, ifu_rdata,
      output lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      input  lsu_ready, lsu_rvalid, lsu_rdata,
      input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata,
      input  busy, err
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb -- two-requester (IFU, LSU) arbiter onto a single memory port,
// one transaction outstanding, round-robin on ties.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-low reset (0 = reset)
//   bus  : mem_arb_if.slave, all requester / memory / status signals
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; grant a valid requester, latch its payload
// REQ   | mem_valid held with latched payload until mem_ready
// WAIT  | waiting for mem_rvalid; forward it to the owner, back to IDLE
module mem_arb #(
   parameter int XLEN  = 32,
   parameter int MASKW = XLEN/8
) (
   input logic     clk,
   input logic     rst,
   mem_arb_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             rr_last_q, rr_last_d;
   logic             err_q, err_d;
   logic             wen_q, wen_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [MASKW-1:0] wmask_q, wmask_d;

   logic in_idle, in_req, in_wait;
   logic gnt_ifu, gnt_lsu, rsp_fire;

   // All status decodes are qualified by rst so that every output is quiet
   // while reset is held, not only after the reset edge.
   always_comb begin
      in_idle  = rst && (state_q == ST_IDLE);
      in_req   = rst && (state_q == ST_REQ);
      in_wait  = rst && (state_q == ST_WAIT);
      // LSU wins a tie only when IFU was granted last.
      gnt_lsu  = in_idle && bus.lsu_valid && (!bus.ifu_valid || (rr_last_q == OWN_IFU));
      gnt_ifu  = in_idle && bus.ifu_valid && !gnt_lsu;
      rsp_fire = in_wait && bus.mem_rvalid;
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      err_d     = err_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;

      case (state_q)
         ST_IDLE: begin
            if (gnt_lsu) begin
               owner_d   = OWN_LSU;
               rr_last_d = OWN_LSU;
               wen_d     = bus.lsu_wen;
               addr_d    = bus.lsu_addr;
               wdata_d   = bus.lsu_wdata;
               wmask_d   = bus.lsu_wmask;
               state_d   = ST_REQ;
            end else if (gnt_ifu) begin
               owner_d   = OWN_IFU;
               rr_last_d = OWN_IFU;
               wen_d     = 1'b0;
               addr_d    = bus.ifu_addr;
               wdata_d   = '0;
               wmask_d   = '0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.mem_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_rvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A response with nothing outstanding (including one belonging to a
      // transaction abandoned by reset) is a protocol error; sticky.
      if (bus.mem_rvalid && (state_q != ST_WAIT)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_IFU;
         rr_last_q <= OWN_IFU;
         err_q     <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         err_q     <= err_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
      end
   end

   assign bus.ifu_ready  = gnt_ifu;
   assign bus.lsu_ready  = gnt_lsu;

   assign bus.ifu_rvalid = rsp_fire && (owner_q == OWN_IFU);
   assign bus.lsu_rvalid = rsp_fire && (owner_q == OWN_LSU);
   assign bus.ifu_rdata  = bus.ifu_rvalid ? bus.mem_rdata : '0;
   assign bus.lsu_rdata  = bus.lsu_rvalid ? bus.mem_rdata : '0;

   // Payload is exposed only while the request is presented.
   assign bus.mem_valid  = in_req;
   assign bus.mem_wen    = in_req && wen_q;
   assign bus.mem_addr   = in_req ? addr_q  : '0;
   assign bus.mem_wdata  = in_req ? wdata_q : '0;
   assign bus.mem_wmask  = in_req ? wmask_q : '0;

   assign bus.busy       = rst && (state_q != ST_IDLE);
   assign bus.err        = rst && err_q;

endmodule
